// File: rtl/platform_pkg.sv
// Shared types and tile geometry for the platform/pool sprite renderer.
package platform_pkg;

    typedef enum logic [1:0] {
        PLATFORM = 2'b00,
        WATER    = 2'b01,
        FIRE     = 2'b10
    } platform_type_e;

    // Tile geometry: platforms are 64x8, water and fire pools are 49x10.
    localparam logic [6:0]  PLATFORM_W = 7'd64;
    localparam logic [3:0]  PLATFORM_H = 4'd8;
    localparam logic [6:0]  POOL_W     = 7'd49;
    localparam logic [3:0]  POOL_H     = 4'd10;

    localparam logic [11:0] TRANSPARENT_DEFAULT = 12'hF0F;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  ptype;
        logic [3:0]  tiles;
    } platform_entry_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_stream_t;

    function automatic logic [6:0] tile_w(input logic [1:0] t);
        return (t == PLATFORM) ? PLATFORM_W : POOL_W;
    endfunction

    function automatic logic [3:0] tile_h(input logic [1:0] t);
        return (t == PLATFORM) ? PLATFORM_H : POOL_H;
    endfunction

    // Type 2'b11 and a zero tile count both mean the slot is unused.
    function automatic logic entry_enabled(input platform_entry_t e);
        return (e.tiles != 4'd0) && (e.ptype != 2'b11);
    endfunction

endpackage

// File: rtl/platform_render_if.sv
// Object-table programming bus: staging writes, commit request, commit ack.
interface platform_render_if #(
    parameter int IDX_W = 3
);
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_idx;
    logic [10:0]      tbl_x;
    logic [10:0]      tbl_y;
    logic [1:0]       tbl_type;
    logic [3:0]       tbl_tiles;
    logic             tbl_commit;
    logic             commit_done;

    modport master (
        output tbl_we, tbl_idx, tbl_x, tbl_y, tbl_type, tbl_tiles, tbl_commit,
        input  commit_done
    );

    modport slave (
        input  tbl_we, tbl_idx, tbl_x, tbl_y, tbl_type, tbl_tiles, tbl_commit,
        output commit_done
    );
endinterface

// File: rtl/platform_hit.sv
// Per-object coverage test: tracks column/tile position along the current
// line and produces hit, ROM address and type for the current pixel.
module platform_hit
    import platform_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  platform_entry_t entry,
    input  logic [10:0]     hcount_in,
    input  logic [10:0]     vcount_in,
    input  logic            hblnk_in,
    input  logic            vblnk_in,
    output logic            hit,
    output logic [11:0]     address,
    output logic [1:0]      ptype
);

    logic [5:0]  col_q, col_d;
    logic [3:0]  tile_q, tile_d;
    logic        span_q, span_d;

    logic [6:0]  w;
    logic [3:0]  h;
    logic [11:0] row_full;
    logic [11:0] row12;
    logic [3:0]  row;
    logic        on_line;
    logic        last_col;

    // Column counter replaces (hcount - x) mod W: the registered state holds
    // the previous pixel's position, the current one is derived from it.
    always_comb begin
        w        = tile_w(entry.ptype);
        h        = tile_h(entry.ptype);
        row_full = {1'b0, vcount_in} - {1'b0, entry.y};
        on_line  = entry_enabled(entry) && (vcount_in >= entry.y) &&
                   (row_full < {8'd0, h});
        row      = row_full[3:0];
        row12    = {8'd0, row};
        last_col = ({1'b0, col_q} == (w - 7'd1));

        col_d  = col_q;
        tile_d = tile_q;
        span_d = 1'b0;
        if (on_line && !hblnk_in && !vblnk_in) begin
            if (hcount_in == entry.x) begin
                col_d  = '0;
                tile_d = '0;
                span_d = 1'b1;
            end else if (span_q) begin
                if (last_col) begin
                    col_d  = '0;
                    tile_d = tile_q + 4'd1;
                    span_d = ((tile_q + 4'd1) != entry.tiles);
                end else begin
                    col_d  = col_q + 6'd1;
                    span_d = 1'b1;
                end
            end
        end

        hit   = span_d;
        ptype = entry.ptype;
        if (entry.ptype == PLATFORM) begin
            address = {3'd0, row[2:0], col_d};
        end else begin
            address = (row12 << 5) + (row12 << 4) + row12 + {6'd0, col_d};
        end
    end

    // Position state for the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            tile_q <= '0;
            span_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            tile_q <= tile_d;
            span_q <= span_d;
        end
    end

endmodule

// File: rtl/platform_render.sv
// Platform/pool compositor: double-buffered object table, per-pixel priority
// hit select, ROM address issue and 3-clock re-timed VGA stream.
module platform_render
    import platform_pkg::*;
#(
    parameter int          NUM_ENTRIES = 8,
    parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [10:0]         hcount_in,
    input  logic [10:0]         vcount_in,
    input  logic                hsync_in,
    input  logic                hblnk_in,
    input  logic                vsync_in,
    input  logic                vblnk_in,
    input  logic [11:0]         rgb_in,
    platform_render_if.slave    tbl,
    output logic [11:0]         rom_address,
    output logic [1:0]          rom_type,
    input  logic [11:0]         rom_rgb,
    output logic [10:0]         hcount_out,
    output logic [10:0]         vcount_out,
    output logic                hsync_out,
    output logic                hblnk_out,
    output logic                vsync_out,
    output logic                vblnk_out,
    output logic [11:0]         rgb_out
);

    platform_entry_t staging_q [NUM_ENTRIES];
    platform_entry_t staging_d [NUM_ENTRIES];
    platform_entry_t active_q  [NUM_ENTRIES];
    platform_entry_t active_d  [NUM_ENTRIES];

    logic pending_q, pending_d;
    logic vblnk_prev_q, vblnk_prev_d;
    logic commit_done_q, commit_done_d;
    logic apply;

    logic [NUM_ENTRIES-1:0] ent_hit;
    logic [11:0]            ent_addr [NUM_ENTRIES];
    logic [1:0]             ent_type [NUM_ENTRIES];

    logic        sel_hit;
    logic [11:0] sel_addr;
    logic [1:0]  sel_type;

    vga_stream_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        hit1_q, hit1_d, hit2_q, hit2_d;
    logic [11:0] rom_address_q, rom_address_d;
    logic [1:0]  rom_type_q, rom_type_d;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : gen_hit
        platform_hit u_hit (
            .clk       (clk),
            .rst       (rst),
            .entry     (active_q[g]),
            .hcount_in (hcount_in),
            .vcount_in (vcount_in),
            .hblnk_in  (hblnk_in),
            .vblnk_in  (vblnk_in),
            .hit       (ent_hit[g]),
            .address   (ent_addr[g]),
            .ptype     (ent_type[g])
        );
    end

    // Staging writes, commit request and frame-boundary copy to the active table.
    always_comb begin
        apply     = pending_q && vblnk_in && !vblnk_prev_q;
        staging_d = staging_q;
        if (tbl.tbl_we) begin
            staging_d[tbl.tbl_idx] = '{x: tbl.tbl_x, y: tbl.tbl_y,
                                       ptype: tbl.tbl_type, tiles: tbl.tbl_tiles};
        end
        active_d      = apply ? staging_q : active_q;
        pending_d     = (pending_q && !apply) || tbl.tbl_commit;
        vblnk_prev_d  = vblnk_in;
        commit_done_d = apply;
    end

    // Lowest-index covering object wins.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        sel_type = PLATFORM;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!sel_hit && ent_hit[i]) begin
                sel_hit  = 1'b1;
                sel_addr = ent_addr[i];
                sel_type = ent_type[i];
            end
        end
    end

    // Three-stage stream delay; the ROM answers between S1 and S3.
    always_comb begin
        s1_d          = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                          hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in,
                          rgb: rgb_in};
        hit1_d        = sel_hit;
        rom_address_d = sel_hit ? sel_addr : '0;
        rom_type_d    = sel_hit ? sel_type : PLATFORM;
        s2_d          = s1_q;
        hit2_d        = hit1_q;
        s3_d          = s2_q;
        if (hit2_q && (rom_rgb != TRANSPARENT)) begin
            s3_d.rgb = rom_rgb;
        end
    end

    // All state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                staging_q[i] <= '0;
                active_q[i]  <= '0;
            end
            pending_q     <= 1'b0;
            vblnk_prev_q  <= 1'b0;
            commit_done_q <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            hit1_q        <= 1'b0;
            hit2_q        <= 1'b0;
            rom_address_q <= '0;
            rom_type_q    <= '0;
        end else begin
            staging_q     <= staging_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            vblnk_prev_q  <= vblnk_prev_d;
            commit_done_q <= commit_done_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            hit1_q        <= hit1_d;
            hit2_q        <= hit2_d;
            rom_address_q <= rom_address_d;
            rom_type_q    <= rom_type_d;
        end
    end

    assign tbl.commit_done = commit_done_q;
    assign rom_address     = rom_address_q;
    assign rom_type        = rom_type_q;
    assign hcount_out      = s3_q.hcount;
    assign vcount_out      = s3_q.vcount;
    assign hsync_out       = s3_q.hsync;
    assign hblnk_out       = s3_q.hblnk;
    assign vsync_out       = s3_q.vsync;
    assign vblnk_out       = s3_q.vblnk;
    assign rgb_out         = s3_q.rgb;

endmodule

// File: tb/tb_platform_render.sv
// Scoreboard bench for platform_render: driver pushes expected responses from
// a geometric reference model, monitor pops and compares after each edge.
module tb_platform_render;

    localparam int          NE     = 8;
    localparam logic [11:0] TRANSP = 12'hF0F;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] rom_address;
    logic [1:0]  rom_type;
    logic [11:0] rom_rgb;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    platform_render_if #(.IDX_W(3)) tbl_bus ();

    platform_render #(.NUM_ENTRIES(NE), .TRANSPARENT(TRANSP)) dut (
        .clk         (clk),
        .rst         (rst),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .hblnk_in    (hblnk_in),
        .vsync_in    (vsync_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .tbl         (tbl_bus),
        .rom_address (rom_address),
        .rom_type    (rom_type),
        .rom_rgb     (rom_rgb),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .hblnk_out   (hblnk_out),
        .vsync_out   (vsync_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sprite ROM stand-in: arbitrary colour per (address, type), some pixels see-through.
    function automatic logic [11:0] rom_f(input logic [11:0] a, input logic [1:0] t);
        int v;
        v = int'(a) * 37 + int'(t) * 1001 + 5;
        if ((int'(a) % 7) == 3) return TRANSP;
        return v[11:0];
    endfunction

    always @(posedge clk) rom_rgb <= rom_f(rom_address, rom_type);

    typedef struct {int x; int y; int t; int n;} ment_t;
    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [1:0]  typ;
        logic        cd;
        int          want_addr;
        int          want_typ;
        string       tag;
    } e1_t;
    typedef struct {int due; logic [37:0] s;} e3_t;

    ment_t mstage [NE];
    ment_t mactive[NE];
    bit    mpend, mprev;
    e1_t   q1[$];
    e3_t   q3[$];

    int total = 0, bad = 0, edge_cnt = 0, cd_seen = 0;

    logic  d_we, d_commit;
    int    d_idx, d_x, d_y, d_t, d_n;
    int    d_wa, d_wt;
    string d_tag;

    task automatic step(input logic r, input int h, input int v);
        logic hb, vb, hs, vs, hit, ap;
        logic [11:0] rgb, romv, rgbx;
        int w, hh, a, ty, k;
        hb  = (h >= 512);
        hs  = (h >= 514 && h < 518);
        vb  = (v >= 600);
        vs  = (v == 600);
        rgb = 12'($urandom);
        @(negedge clk);
        rst       = r;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = rgb;
        tbl_bus.tbl_we     = d_we;
        tbl_bus.tbl_idx    = 3'(d_idx);
        tbl_bus.tbl_x      = 11'(d_x);
        tbl_bus.tbl_y      = 11'(d_y);
        tbl_bus.tbl_type   = 2'(d_t);
        tbl_bus.tbl_tiles  = 4'(d_n);
        tbl_bus.tbl_commit = d_commit;
        k = edge_cnt + 1;

        hit = 1'b0; a = 0; ty = 0;
        if (!r && !hb && !vb) begin
            for (int e = 0; e < NE; e++) begin
                if (!hit && mactive[e].n != 0 && mactive[e].t != 3) begin
                    w  = (mactive[e].t == 0) ? 64 : 49;
                    hh = (mactive[e].t == 0) ? 8 : 10;
                    if (h >= mactive[e].x && h < mactive[e].x + mactive[e].n * w &&
                        v >= mactive[e].y && v < mactive[e].y + hh) begin
                        hit = 1'b1;
                        a   = (v - mactive[e].y) * w + (h - mactive[e].x) % w;
                        ty  = mactive[e].t;
                    end
                end
            end
        end
        ap   = !r && mpend && vb && !mprev;
        romv = rom_f(12'(a), 2'(ty));
        rgbx = (hit && romv != TRANSP) ? romv : rgb;

        if (r) begin
            foreach (q3[i]) if (q3[i].due >= k) q3[i].s = '0;
            q1.push_back('{k, 12'd0, 2'd0, 1'b0, d_wa, d_wt, d_tag});
            q3.push_back('{k + 2, 38'd0});
            foreach (mstage[i]) begin
                mstage[i]  = '{0, 0, 0, 0};
                mactive[i] = '{0, 0, 0, 0};
            end
            mpend = 1'b0;
            mprev = 1'b0;
        end else begin
            q1.push_back('{k, 12'(a), 2'(ty), ap, d_wa, d_wt, d_tag});
            q3.push_back('{k + 2, {11'(h), 11'(v), hs, hb, vs, vb, rgbx}});
            if (ap) mactive = mstage;
            if (d_we) mstage[d_idx] = '{d_x, d_y, d_t, d_n};
            mpend = (mpend && !ap) || d_commit;
            mprev = vb;
        end
    endtask

    task automatic wr(input int idx, input int x, input int y, input int t, input int n);
        d_we = 1'b1; d_idx = idx; d_x = x; d_y = y; d_t = t; d_n = n;
    endtask

    task automatic events(input int f, input int v, input int h);
        if (f == 0 && v == 199) begin
            if (h == 10) wr(0, 100, 200, 0, 2);
            if (h == 11) begin wr(1, 300, 400, 1, 1); d_commit = 1'b1; end
            if (h == 12) wr(2, 50, 201, 1, 0);
            if (h == 13) d_commit = 1'b1;
        end
        if (f == 0 && v == 400 && h == 20) wr(5, 50, 405, 2, 1);
        if (f == 1 && v == 204) begin
            if (h == 0) wr(0, 120, 200, 0, 2);
            if (h == 1) d_commit = 1'b1;
        end
        if (f == 2 && v == 199) begin
            if (h == 20) wr(0, 100, 200, 2, 1);
            if (h == 21) wr(3, 100, 200, 0, 2);
            if (h >= 22 && h <= 24)
                wr((h == 22) ? 4 : (h == 23) ? 6 : 7, $urandom_range(0, 400),
                   ($urandom_range(0, 1) == 0) ? 199 + $urandom_range(0, 7)
                                               : 399 + $urandom_range(0, 6),
                   $urandom_range(0, 3), $urandom_range(0, 4));
            if (h == 25) d_commit = 1'b1;
        end
    endtask

    task automatic want(input int f, input int v, input int h);
        if (f == 1 && v == 203 && h == 100) begin d_wa = 192; d_wt = 0; d_tag = "f1_x100"; end
        if (f == 1 && v == 203 && h == 227) begin d_wa = 255; d_wt = 0; d_tag = "f1_last_px"; end
        if (f == 1 && v == 203 && h == 228) begin d_wa = 0;   d_wt = 0; d_tag = "f1_past_end"; end
        if (f == 1 && v == 206 && h == 100) begin d_wa = 384; d_wt = 0; d_tag = "f1_midframe_hold"; end
        if (f == 1 && v == 409 && h == 348) begin d_wa = 489; d_wt = 1; d_tag = "f1_water"; end
        if (f == 2 && v == 203 && h == 100) begin d_wa = 0;   d_wt = 0; d_tag = "f2_old_x"; end
        if (f == 2 && v == 203 && h == 120) begin d_wa = 192; d_wt = 0; d_tag = "f2_new_x"; end
        if (f == 3 && v == 205 && h == 110) begin d_wa = 255; d_wt = 2; d_tag = "f3_fire_wins"; end
        if (f == 3 && v == 205 && h == 160) begin d_wa = 380; d_wt = 0; d_tag = "f3_platform"; end
        if (f == 3 && v == 206 && h == 110) begin d_wa = 0;   d_wt = 0; d_tag = "f3_after_rst"; end
    endtask

    task automatic run_frame(input int f);
        int lines[$];
        for (int v = 199; v <= 208; v++) lines.push_back(v);
        for (int v = 399; v <= 410; v++) lines.push_back(v);
        lines.push_back(600);
        lines.push_back(601);
        foreach (lines[li]) begin
            for (int h = 0; h < 520; h++) begin
                d_we = 1'b0; d_commit = 1'b0; d_wa = -1; d_wt = 0; d_tag = "";
                events(f, lines[li], h);
                want(f, lines[li], h);
                step(f == 3 && lines[li] == 205 && (h == 500 || h == 501), h, lines[li]);
            end
        end
    endtask

    // Monitor: compare whatever is due after each rising edge.
    initial begin
        e1_t e1;
        e3_t e3;
        logic [37:0] got;
        forever begin
            @(posedge clk);
            #2;
            edge_cnt++;
            while (q1.size() > 0 && q1[0].due <= edge_cnt) begin
                e1 = q1.pop_front();
                total++;
                if ({rom_address, rom_type} !== {e1.addr, e1.typ}) begin
                    bad++;
                    $display("FAIL rom edge=%0d got addr=%0d type=%0d want addr=%0d type=%0d",
                             edge_cnt, rom_address, rom_type, e1.addr, e1.typ);
                end
                total++;
                if (tbl_bus.commit_done !== e1.cd) begin
                    bad++;
                    $display("FAIL commit_done edge=%0d got=%b want=%b",
                             edge_cnt, tbl_bus.commit_done, e1.cd);
                end
                if (tbl_bus.commit_done === 1'b1) cd_seen++;
                if (e1.want_addr >= 0) begin
                    total++;
                    if (int'(rom_address) != e1.want_addr || int'(rom_type) != e1.want_typ) begin
                        bad++;
                        $display("FAIL %s got addr=%0d type=%0d want addr=%0d type=%0d",
                                 e1.tag, rom_address, rom_type, e1.want_addr, e1.want_typ);
                    end
                end
            end
            while (q3.size() > 0 && q3[0].due <= edge_cnt) begin
                e3  = q3.pop_front();
                got = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};
                total++;
                if (got !== e3.s) begin
                    bad++;
                    $display("FAIL stream edge=%0d got=%h want=%h", edge_cnt, got, e3.s);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog edge=%0d", edge_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = '0;
        tbl_bus.tbl_we = 1'b0; tbl_bus.tbl_idx = '0; tbl_bus.tbl_x = '0; tbl_bus.tbl_y = '0;
        tbl_bus.tbl_type = '0; tbl_bus.tbl_tiles = '0; tbl_bus.tbl_commit = 1'b0;
        d_we = 1'b0; d_commit = 1'b0; d_idx = 0; d_x = 0; d_y = 0; d_t = 0; d_n = 0;
        d_wa = -1; d_wt = 0; d_tag = "";
        mpend = 1'b0; mprev = 1'b0;
        foreach (mstage[i]) begin
            mstage[i]  = '{0, 0, 0, 0};
            mactive[i] = '{0, 0, 0, 0};
        end

        repeat (3) step(1'b1, 0, 0);
        for (int f = 0; f < 4; f++) run_frame(f);
        d_we = 1'b0; d_commit = 1'b0; d_wa = -1; d_tag = "";
        repeat (5) step(1'b0, 0, 0);
        repeat (4) @(negedge clk);

        total++;
        if (cd_seen != 3) begin
            bad++;
            $display("FAIL commit_done_count got=%0d want=3", cd_seen);
        end
        total++;
        if (q1.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d,%0d want=0,0", q1.size(), q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
